// File: rtl/spi_sensor_arbiter.sv
// spi_sensor_arbiter
//  Shares a single SPI master between NUM_REQ sensor readers. A round-robin
//  grant is held for one complete SPI frame: the arbiter raises spi_ena and
//  the winner's chip select, waits for the master to go busy and then idle
//  again, hands the received word back with a one-cycle done pulse, and then
//  keeps every chip select high for GAP_CYCLES cycles before the next frame.
//  Optional feature: define SPI_ARB_TIMEOUT_EN to add a frame watchdog that
//  aborts a frame after TIMEOUT_CYCLES cycles in START+BUSY. The aborted frame
//  returns 32'hFFFF_FFFF with done and timeout_err pulsing together.
module spi_sensor_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [NUM_REQ-1:0] done,
   output logic [31:0]        rx_data,
   output logic               timeout_err,
   output logic               spi_ena,
   input  logic               spi_not_busy,
   input  logic [31:0]        spi_rx_data,
   output logic [NUM_REQ-1:0] spi_cs_n
);

   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int GAPW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [IDXW-1:0] PTR_RST  = IDXW'(NUM_REQ - 1);
   localparam logic [GAPW-1:0] GAP_LAST = GAPW'(GAP_CYCLES - 1);

   // Reject configurations the arbiter is not built for
   if ((NUM_REQ < 2) || (NUM_REQ > 8) || (GAP_CYCLES < 1) ||
       (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_param_check
      $error("spi_sensor_arbiter: parameter out of range");
   end

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_BUSY  = 3'd2,
      ST_DONE  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   state_t             state_r, state_s;
   logic [IDXW-1:0]    idx_r, idx_s;
   logic [IDXW-1:0]    ptr_r, ptr_s;
   logic [NUM_REQ-1:0] gnt_r, gnt_s;
   logic [NUM_REQ-1:0] done_r, done_s;
   logic [NUM_REQ-1:0] cs_n_r, cs_n_s;
   logic [31:0]        rx_data_r, rx_data_s;
   logic               spi_ena_r, spi_ena_s;
   logic [GAPW-1:0]    gap_cnt_r, gap_cnt_s;

   logic               found_s;
   logic [IDXW-1:0]    winner_s;
   logic [IDXW:0]      sum_s;
   logic [IDXW-1:0]    cand_s;
   logic               hit_s;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]        wd_r, wd_s;
   logic               tmo_r, tmo_s;
`endif

   // One-hot vector with only the given client's bit set
   function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDXW-1:0] i);
      to_onehot = NUM_REQ'(1'b1) << i;
   endfunction

   // Round-robin search: first requester after the last winner, wrapping to 0
   always_comb begin
      found_s  = 1'b0;
      winner_s = '0;
      sum_s    = '0;
      cand_s   = '0;
      hit_s    = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         sum_s    = {1'b0, ptr_r} + (IDXW+1)'(i);
         cand_s   = (sum_s >= (IDXW+1)'(NUM_REQ)) ? IDXW'(sum_s - (IDXW+1)'(NUM_REQ))
                                                  : sum_s[IDXW-1:0];
         hit_s    = !found_s && req[cand_s];
         winner_s = hit_s ? cand_s : winner_s;
         found_s  = found_s | hit_s;
      end
   end

   // Next-state and next-output logic for the frame sequencer
   always_comb begin
      state_s   = state_r;
      idx_s     = idx_r;
      ptr_s     = ptr_r;
      gnt_s     = gnt_r;
      cs_n_s    = cs_n_r;
      spi_ena_s = spi_ena_r;
      rx_data_s = rx_data_r;
      done_s    = '0;
      gap_cnt_s = gap_cnt_r;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_s     = 1'b0;
      wd_s      = 16'd0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               idx_s     = winner_s;
               ptr_s     = winner_s;
               gnt_s     = to_onehot(winner_s);
               cs_n_s    = ~to_onehot(winner_s);
               spi_ena_s = 1'b1;
               state_s   = ST_START;
            end else begin
               gnt_s     = '0;
               cs_n_s    = '1;
               spi_ena_s = 1'b0;
               state_s   = ST_IDLE;
            end
         end
         ST_START: begin
            // Hold the request until the master reports it has taken the frame
            if (!spi_not_busy) begin
               spi_ena_s = 1'b0;
               state_s   = ST_BUSY;
            end else begin
               spi_ena_s = 1'b1;
               state_s   = ST_START;
            end
         end
         ST_BUSY: begin
            if (spi_not_busy) begin
               rx_data_s = spi_rx_data;
               done_s    = to_onehot(idx_r);
               state_s   = ST_DONE;
            end else begin
               state_s   = ST_BUSY;
            end
         end
         ST_DONE: begin
            gnt_s     = '0;
            cs_n_s    = '1;
            spi_ena_s = 1'b0;
            gap_cnt_s = '0;
            state_s   = ST_GAP;
         end
         ST_GAP: begin
            if (gap_cnt_r == GAP_LAST) begin
               gap_cnt_s = '0;
               state_s   = ST_IDLE;
            end else begin
               gap_cnt_s = gap_cnt_r + GAPW'(1'b1);
               state_s   = ST_GAP;
            end
         end
         default: begin
            gnt_s     = '0;
            cs_n_s    = '1;
            spi_ena_s = 1'b0;
            gap_cnt_s = '0;
            state_s   = ST_IDLE;
         end
      endcase
`ifdef SPI_ARB_TIMEOUT_EN
      // Watchdog runs only while a frame is outstanding; an expiry wins over a
      // completion seen in the same cycle
      if ((state_r == ST_START) || (state_r == ST_BUSY)) begin
         if (wd_r == WD_LAST) begin
            spi_ena_s = 1'b0;
            rx_data_s = 32'hFFFF_FFFF;
            done_s    = to_onehot(idx_r);
            tmo_s     = 1'b1;
            wd_s      = 16'd0;
            state_s   = ST_DONE;
         end else begin
            wd_s      = wd_r + 16'd1;
         end
      end else begin
         wd_s = 16'd0;
      end
`endif
   end

   // State and output registers; a synchronous reset aborts any frame in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         idx_r     <= '0;
         ptr_r     <= PTR_RST;
         gnt_r     <= '0;
         done_r    <= '0;
         cs_n_r    <= '1;
         rx_data_r <= 32'd0;
         spi_ena_r <= 1'b0;
         gap_cnt_r <= '0;
      end else begin
         state_r   <= state_s;
         idx_r     <= idx_s;
         ptr_r     <= ptr_s;
         gnt_r     <= gnt_s;
         done_r    <= done_s;
         cs_n_r    <= cs_n_s;
         rx_data_r <= rx_data_s;
         spi_ena_r <= spi_ena_s;
         gap_cnt_r <= gap_cnt_s;
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   // Watchdog counter and its error flag register
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_r  <= 16'd0;
         tmo_r <= 1'b0;
      end else begin
         wd_r  <= wd_s;
         tmo_r <= tmo_s;
      end
   end

   assign timeout_err = tmo_r;
`else
   assign timeout_err = 1'b0;
`endif

   assign gnt      = gnt_r;
   assign done     = done_r;
   assign rx_data  = rx_data_r;
   assign spi_ena  = spi_ena_r;
   assign spi_cs_n = cs_n_r;

endmodule

// File: tb/tb_spi_sensor_arbiter.sv
// tb_spi_sensor_arbiter
//  Drives spi_sensor_arbiter with directed and randomized requests plus a
//  behavioural SPI master, and compares every cycle against a frame-level
//  reference model (grant order, frame occupancy, gap, returned word).
//  Build with SPI_ARB_TIMEOUT_EN defined to include the watchdog scenario.
module tb_spi_sensor_arbiter;

   localparam int NUM_REQ        = 3;
   localparam int GAP_CYCLES     = 4;
   localparam int TIMEOUT_CYCLES = 20;
`ifdef SPI_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic               clk;
   logic               rst;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic [NUM_REQ-1:0] done;
   logic [31:0]        rx_data;
   logic               timeout_err;
   logic               spi_ena;
   logic               spi_not_busy;
   logic [31:0]        spi_rx_data;
   logic [NUM_REQ-1:0] spi_cs_n;

   spi_sensor_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .GAP_CYCLES     (GAP_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .gnt          (gnt),
      .done         (done),
      .rx_data      (rx_data),
      .timeout_err  (timeout_err),
      .spi_ena      (spi_ena),
      .spi_not_busy (spi_not_busy),
      .spi_rx_data  (spi_rx_data),
      .spi_cs_n     (spi_cs_n)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model state (frame level)
   bit                 in_frame  = 1'b0;
   bit                 saw_busy  = 1'b0;
   int                 holdoff   = 0;
   int                 last_win  = NUM_REQ - 1;
   int                 cur       = 0;
   int                 since     = 0;
   int                 grant_cyc = 0;
   int                 last_done_cyc = -1;
   logic [NUM_REQ-1:0] exp_gnt   = '0;
   logic [NUM_REQ-1:0] exp_done  = '0;
   logic               exp_ena   = 1'b0;
   logic               exp_tmo   = 1'b0;
   logic [31:0]        exp_rx    = 32'd0;
   int                 win_log[$];

   // Behavioural SPI master state
   int                 spi_phase  = 0;
   int                 busy_left  = 0;
   int                 force_len  = 0;
   logic [31:0]        force_word = 32'd0;
   bit                 stuck      = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Advance the model by one clock edge, given the inputs present at that edge
   task automatic model_edge(input logic [NUM_REQ-1:0] req_e, input logic nb_e,
                             input logic rst_e, input logic [31:0] rxw_e);
      bit frame_end;
      bit found;
      int c;
      frame_end = 1'b0;
      exp_done  = '0;
      exp_tmo   = 1'b0;
      if (rst_e) begin
         in_frame = 1'b0; holdoff = 0; last_win = NUM_REQ - 1;
         exp_gnt = '0; exp_ena = 1'b0; exp_rx = 32'd0; last_done_cyc = -1;
      end else if (in_frame) begin
         since++;
         if (TMO_EN && (since == TIMEOUT_CYCLES)) begin
            exp_tmo = 1'b1; exp_rx = 32'hFFFF_FFFF; frame_end = 1'b1;
         end else if (!saw_busy) begin
            if (!nb_e) saw_busy = 1'b1;
         end else if (nb_e) begin
            exp_rx = rxw_e; frame_end = 1'b1;
         end
         exp_ena = !saw_busy;
         if (frame_end) begin
            exp_done[cur] = 1'b1;
            exp_ena  = 1'b0;
            in_frame = 1'b0;
            holdoff  = GAP_CYCLES + 1;
            if (last_done_cyc >= 0)
               check_eq("done_spacing", 32'(cyc - last_done_cyc >= GAP_CYCLES + 4), 32'd1);
            last_done_cyc = cyc;
         end
      end else if (holdoff > 0) begin
         holdoff--; exp_gnt = '0; exp_ena = 1'b0;
      end else if (req_e != '0) begin
         found = 1'b0;
         for (int k = 1; k <= NUM_REQ; k++) begin
            c = (last_win + k) % NUM_REQ;
            if (!found && req_e[c]) begin
               found = 1'b1; cur = c;
            end
         end
         last_win = cur; in_frame = 1'b1; saw_busy = 1'b0; since = 0; grant_cyc = cyc;
         exp_gnt = '0; exp_gnt[cur] = 1'b1; exp_ena = 1'b1;
         win_log.push_back(cur);
      end else begin
         exp_gnt = '0; exp_ena = 1'b0;
      end
   endtask

   // Behavioural SPI master: accepts spi_ena, stays busy a while, then returns a word
   task automatic spi_drive(input logic rst_e);
      if (rst_e) begin
         spi_phase = 0; spi_not_busy = 1'b1;
      end else if (stuck) begin
         spi_not_busy = 1'b0;
      end else if (spi_phase == 0) begin
         if (spi_ena && ((force_len > 0) || ($urandom_range(0, 2) != 0))) begin
            spi_phase    = 1;
            busy_left    = (force_len > 0) ? force_len : int'($urandom_range(1, 6));
            spi_rx_data  = (force_len > 0) ? force_word : $urandom;
            spi_not_busy = 1'b0;
         end else begin
            spi_not_busy = 1'b1;
         end
      end else begin
         busy_left--;
         if (busy_left == 0) begin
            spi_not_busy = 1'b1; spi_phase = 0;
         end
      end
   endtask

   // One clock: capture inputs, clock, check all outputs against the model, drive the SPI side
   task automatic step();
      logic [NUM_REQ-1:0] req_e;
      logic [NUM_REQ-1:0] exp_cs;
      logic               nb_e;
      logic               rst_e;
      logic [31:0]        rxw_e;
      req_e = req; nb_e = spi_not_busy; rst_e = rst; rxw_e = spi_rx_data;
      @(posedge clk);
      #1;
      cyc++;
      model_edge(req_e, nb_e, rst_e, rxw_e);
      exp_cs = ~exp_gnt;
      check_eq("gnt",         32'(gnt),         32'(exp_gnt));
      check_eq("spi_cs_n",    32'(spi_cs_n),    32'(exp_cs));
      check_eq("done",        32'(done),        32'(exp_done));
      check_eq("rx_data",     rx_data,          exp_rx);
      check_eq("spi_ena",     32'(spi_ena),     32'(exp_ena));
      check_eq("timeout_err", 32'(timeout_err), 32'(exp_tmo));
      spi_drive(rst_e);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; req = '0;
      repeat (n) step();
      rst = 1'b0;
      win_log.delete();
   endtask

   task automatic wait_done(input int budget, output logic [NUM_REQ-1:0] seen, output logic tmo_seen);
      seen = '0; tmo_seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (done != '0) begin
            seen = done; tmo_seen = timeout_err;
            break;
         end
      end
      check_eq("done_within_budget", 32'(seen != '0), 32'd1);
   endtask

   task automatic wait_grant(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (gnt != '0) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("grant_within_budget", 32'(ok), 32'd1);
   endtask

   logic [NUM_REQ-1:0] seen;
   logic               tmo_seen;
   int                 exp_order[4] = '{0, 1, 2, 0};

   // Test sequence
   initial begin
      rst = 1'b1; req = '0; spi_not_busy = 1'b1; spi_rx_data = 32'd0;

      // 1: reset values, idle with no requests
      do_reset(2);
      check_eq("t1_cs_n", 32'(spi_cs_n), 32'h7);
      check_eq("t1_rx",   rx_data,       32'd0);
      repeat (5) step();

      // 2: single request, 8-cycle busy frame
      force_len = 8; force_word = 32'h1234_5678;
      req = 3'b001;
      wait_done(40, seen, tmo_seen);
      check_eq("t2_done", 32'(seen), 32'h1);
      check_eq("t2_rx",   rx_data,   32'h1234_5678);
      req = '0;
      repeat (GAP_CYCLES) begin
         step();
         check_eq("t2_gap_cs_n", 32'(spi_cs_n), 32'h7);
      end
      repeat (4) step();

      // 3: all clients requesting, strict rotation from client 0
      force_len = 0;
      do_reset(2);
      req = 3'b111;
      for (int f = 0; f < 4; f++) wait_done(60, seen, tmo_seen);
      check_eq("t3_log_size", 32'(win_log.size()), 32'd4);
      for (int f = 0; f < 4; f++)
         if (f < win_log.size()) check_eq("t3_order", 32'(win_log[f]), 32'(exp_order[f]));
      req = '0;
      repeat (8) step();

      // 4: ptr at 0, req 101 -> client 2 first; dropping req[2] mid-frame still completes
      do_reset(2);
      req = 3'b001;
      wait_done(60, seen, tmo_seen);
      req = 3'b101;
      wait_grant(30);
      step(); step();
      req = 3'b001;
      wait_done(60, seen, tmo_seen);
      check_eq("t4_done2", 32'(seen), 32'h4);
      wait_done(60, seen, tmo_seen);
      check_eq("t4_log_size", 32'(win_log.size()), 32'd3);
      if (win_log.size() == 3) begin
         check_eq("t4_first",  32'(win_log[1]), 32'd2);
         check_eq("t4_second", 32'(win_log[2]), 32'd0);
      end
      req = '0;
      repeat (8) step();

      // 5: reset during BUSY aborts the frame without a done pulse
      do_reset(2);
      force_len = 12; force_word = 32'hA5A5_0F0F;
      req = 3'b010;
      wait_grant(30);
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0; req = '0;
      check_eq("t5_gnt",  32'(gnt),      32'd0);
      check_eq("t5_cs_n", 32'(spi_cs_n), 32'h7);
      check_eq("t5_ena",  32'(spi_ena),  32'd0);
      check_eq("t5_rx",   rx_data,       32'd0);
      repeat (15) step();
      force_len = 0;

`ifdef SPI_ARB_TIMEOUT_EN
      // 6: stuck master, watchdog aborts, next frame normal
      do_reset(2);
      stuck = 1'b1; spi_not_busy = 1'b0;
      req = 3'b001;
      wait_done(40, seen, tmo_seen);
      check_eq("t6_tmo",     32'(tmo_seen),       32'd1);
      check_eq("t6_latency", 32'(cyc - grant_cyc), 32'(TIMEOUT_CYCLES));
      check_eq("t6_rx",      rx_data,             32'hFFFF_FFFF);
      stuck = 1'b0; spi_not_busy = 1'b1; spi_phase = 0;
      wait_done(40, seen, tmo_seen);
      check_eq("t6_next_tmo", 32'(tmo_seen), 32'd0);
      check_eq("t6_next_rx",  rx_data,       spi_rx_data);
      req = '0;
      repeat (8) step();
`endif

      // Randomized traffic with occasional resets
      do_reset(2);
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 7) == 0) req = NUM_REQ'($urandom_range(0, 7));
         rst = ($urandom_range(0, 399) == 0);
         step();
      end
      rst = 1'b0; req = '0;
      repeat (20) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
